// File: rtl/pc_sequencer.sv
// Fetch-address controller: owns the PC and sequences IDLE/RUN/DRAIN/HALT.
// Optional feature: define PC_OVERFLOW_TRAP_EN to trap sequential-step overflow into HALT with pc_fault.
module pc_sequencer #(
  parameter int unsigned PC_WIDTH     = 11,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned PC_STEP      = 1,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                halt_req,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                flush,
  output logic                running,
  output logic                halted,
  output logic                pc_fault
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;

`ifdef PC_OVERFLOW_TRAP_EN
  // Extra carry bit flags a step that would leave the address space.
  logic [PC_WIDTH:0] step_sum;
  assign step_sum = {1'b0, pc_out} + (PC_WIDTH + 1)'(PC_STEP);
`else
  assign pc_fault = 1'b0;
`endif

  // Sequencer state, PC and all status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pc_out    <= PC_WIDTH'(RESET_PC);
      flush     <= 1'b0;
      running   <= 1'b0;
      halted    <= 1'b0;
      drain_cnt <= '0;
`ifdef PC_OVERFLOW_TRAP_EN
      pc_fault  <= 1'b0;
`endif
    end else begin
      flush <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
            pc_out  <= PC_WIDTH'(RESET_PC);
`ifdef PC_OVERFLOW_TRAP_EN
            pc_fault <= 1'b0;
`endif
          end
        end
        RUN: begin
          // A branch squashes any stall or halt from a younger instruction.
          if (branch_taken) begin
            pc_out <= branch_target;
            flush  <= 1'b1;
          end else if (stall) begin
            pc_out <= pc_out;
          end else if (halt_req) begin
            drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
            state     <= DRAIN;
            running   <= 1'b0;
          end else begin
`ifdef PC_OVERFLOW_TRAP_EN
            if (step_sum[PC_WIDTH]) begin
              pc_fault <= 1'b1;
              state    <= HALT;
              running  <= 1'b0;
              halted   <= 1'b1;
            end else begin
              pc_out <= step_sum[PC_WIDTH-1:0];
            end
`else
            pc_out <= pc_out + PC_WIDTH'(PC_STEP);
`endif
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        HALT: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
            halted  <= 1'b0;
            pc_out  <= PC_WIDTH'(RESET_PC);
`ifdef PC_OVERFLOW_TRAP_EN
            pc_fault <= 1'b0;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters; honours PC_OVERFLOW_TRAP_EN).
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [10:0] branch_target;
  logic        halt_req;
  logic [10:0] pc_out;
  logic        flush;
  logic        running;
  logic        halted;
  logic        pc_fault;

  int tests;
  int failed;
  logic [14:0] exp;

  pc_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .pc_out        (pc_out),
    .flush         (flush),
    .running       (running),
    .halted        (halted),
    .pc_fault      (pc_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; stall = 1'b0; branch_taken = 1'b0; halt_req = 1'b0; branch_target = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    exp = {11'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tests++;
    if ({pc_out, flush, running, halted, pc_fault} !== exp) begin
      failed++;
      $display("FAIL reset_state: got pc=%0d fl=%b run=%b hlt=%b flt=%b, want pc=%0d fl=%b run=%b hlt=%b flt=%b",
               pc_out, flush, running, halted, pc_fault, exp[14:4], exp[3], exp[2], exp[1], exp[0]);
    end
    // IDLE ignores everything but start.
    branch_taken = 1'b1; branch_target = 11'd77; halt_req = 1'b1;
    step();
    clear_inputs();
    tests++;
    if ({pc_out, flush, running, halted, pc_fault} !== exp) begin
      failed++;
      $display("FAIL idle_ignores: got pc=%0d fl=%b run=%b hlt=%b, want pc=0 fl=0 run=0 hlt=0",
               pc_out, flush, running, halted);
    end
  endtask

  task automatic test_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp = {11'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tests++;
    if ({pc_out, flush, running, halted, pc_fault} !== exp) begin
      failed++;
      $display("FAIL start_enter_run: got pc=%0d fl=%b run=%b hlt=%b, want pc=0 fl=0 run=1 hlt=0",
               pc_out, flush, running, halted);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = {11'(i), 1'b0, 1'b1, 1'b0, 1'b0};
      tests++;
      if ({pc_out, flush, running, halted, pc_fault} !== exp) begin
        failed++;
        $display("FAIL seq_step%0d: got pc=%0d fl=%b run=%b, want pc=%0d fl=0 run=1",
                 i, pc_out, flush, running, i);
      end
    end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 11'd1024;
    step();
    clear_inputs();
    tests++;
    if (pc_out !== 11'd1024 || flush !== 1'b1 || running !== 1'b1) begin
      failed++;
      $display("FAIL branch_redirect: got pc=%0d fl=%b run=%b, want pc=1024 fl=1 run=1", pc_out, flush, running);
    end
    step();
    tests++;
    if (pc_out !== 11'd1025 || flush !== 1'b0) begin
      failed++;
      $display("FAIL branch_resume: got pc=%0d fl=%b, want pc=1025 fl=0", pc_out, flush);
    end
  endtask

  task automatic test_branch_priority();
    branch_taken = 1'b1; branch_target = 11'd100; stall = 1'b1; halt_req = 1'b1;
    step();
    clear_inputs();
    tests++;
    if (pc_out !== 11'd100 || flush !== 1'b1 || running !== 1'b1 || halted !== 1'b0) begin
      failed++;
      $display("FAIL branch_priority: got pc=%0d fl=%b run=%b hlt=%b, want pc=100 fl=1 run=1 hlt=0",
               pc_out, flush, running, halted);
    end
    step(); step();
    tests++;
    if (pc_out !== 11'd102 || flush !== 1'b0 || running !== 1'b1) begin
      failed++;
      $display("FAIL branch_priority_run: got pc=%0d fl=%b run=%b, want pc=102 fl=0 run=1", pc_out, flush, running);
    end
  endtask

  task automatic test_back_to_back();
    branch_taken = 1'b1; branch_target = 11'd200;
    step();
    branch_target = 11'd300;
    step();
    clear_inputs();
    tests++;
    if (pc_out !== 11'd300 || flush !== 1'b1) begin
      failed++;
      $display("FAIL b2b_branch: got pc=%0d fl=%b, want pc=300 fl=1", pc_out, flush);
    end
    step();
    tests++;
    if (pc_out !== 11'd301 || flush !== 1'b0) begin
      failed++;
      $display("FAIL b2b_resume: got pc=%0d fl=%b, want pc=301 fl=0", pc_out, flush);
    end
  endtask

  task automatic test_stall();
    branch_taken = 1'b1; branch_target = 11'd10;
    step();
    branch_taken = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      halt_req = (i == 1);
      step();
      tests++;
      if (pc_out !== 11'd10 || flush !== 1'b0 || running !== 1'b1) begin
        failed++;
        $display("FAIL stall_hold%0d: got pc=%0d fl=%b run=%b, want pc=10 fl=0 run=1", i, pc_out, flush, running);
      end
    end
    clear_inputs();
    step();
    tests++;
    if (pc_out !== 11'd11 || running !== 1'b1 || halted !== 1'b0) begin
      failed++;
      $display("FAIL stall_release: got pc=%0d run=%b hlt=%b, want pc=11 run=1 hlt=0", pc_out, running, halted);
    end
  endtask

  task automatic test_halt();
    branch_taken = 1'b1; branch_target = 11'd20;
    step();
    branch_taken = 1'b0;
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    // Redirects and stalls during drain must be ignored.
    branch_taken = 1'b1; branch_target = 11'd500; stall = 1'b1;
    tests++;
    if (pc_out !== 11'd20 || running !== 1'b0 || halted !== 1'b0) begin
      failed++;
      $display("FAIL halt_enter_drain: got pc=%0d run=%b hlt=%b, want pc=20 run=0 hlt=0", pc_out, running, halted);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++;
      if (pc_out !== 11'd20 || halted !== 1'b0 || flush !== 1'b0) begin
        failed++;
        $display("FAIL drain_cycle%0d: got pc=%0d hlt=%b fl=%b, want pc=20 hlt=0 fl=0", i, pc_out, halted, flush);
      end
    end
    step();
    clear_inputs();
    tests++;
    if (pc_out !== 11'd20 || halted !== 1'b1 || running !== 1'b0) begin
      failed++;
      $display("FAIL halt_reached: got pc=%0d hlt=%b run=%b, want pc=20 hlt=1 run=0", pc_out, halted, running);
    end
    step();
    tests++;
    if (pc_out !== 11'd20 || halted !== 1'b1) begin
      failed++;
      $display("FAIL halt_frozen: got pc=%0d hlt=%b, want pc=20 hlt=1", pc_out, halted);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (pc_out !== 11'd0 || running !== 1'b1 || halted !== 1'b0) begin
      failed++;
      $display("FAIL restart: got pc=%0d run=%b hlt=%b, want pc=0 run=1 hlt=0", pc_out, running, halted);
    end
    step();
    tests++;
    if (pc_out !== 11'd1) begin
      failed++;
      $display("FAIL restart_step: got pc=%0d, want pc=1", pc_out);
    end
  endtask

  task automatic test_overflow();
    branch_taken = 1'b1; branch_target = 11'd2047;
    step();
    clear_inputs();
    tests++;
    if (pc_out !== 11'd2047 || pc_fault !== 1'b0) begin
      failed++;
      $display("FAIL branch_top_no_trap: got pc=%0d flt=%b, want pc=2047 flt=0", pc_out, pc_fault);
    end
    step();
`ifdef PC_OVERFLOW_TRAP_EN
    tests++;
    if (pc_out !== 11'd2047 || pc_fault !== 1'b1 || halted !== 1'b1 || running !== 1'b0) begin
      failed++;
      $display("FAIL overflow_trap: got pc=%0d flt=%b hlt=%b run=%b, want pc=2047 flt=1 hlt=1 run=0",
               pc_out, pc_fault, halted, running);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (pc_out !== 11'd0 || pc_fault !== 1'b0 || running !== 1'b1) begin
      failed++;
      $display("FAIL trap_restart: got pc=%0d flt=%b run=%b, want pc=0 flt=0 run=1", pc_out, pc_fault, running);
    end
`else
    tests++;
    if (pc_out !== 11'd0 || pc_fault !== 1'b0 || running !== 1'b1 || halted !== 1'b0) begin
      failed++;
      $display("FAIL overflow_wrap: got pc=%0d flt=%b run=%b hlt=%b, want pc=0 flt=0 run=1 hlt=0",
               pc_out, pc_fault, running, halted);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (pc_out !== 11'd0 || running !== 1'b0 || flush !== 1'b0 || halted !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_run: got pc=%0d run=%b fl=%b hlt=%b, want pc=0 run=0 fl=0 hlt=0",
               pc_out, running, flush, halted);
    end
    step();
    tests++;
    if (pc_out !== 11'd0 || running !== 1'b0) begin
      failed++;
      $display("FAIL reset_idle_hold: got pc=%0d run=%b, want pc=0 run=0", pc_out, running);
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_start();
    test_branch();
    test_branch_priority();
    test_back_to_back();
    test_stall();
    test_halt();
    test_overflow();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
